sudoku_ram_arbiter: RTL and testbench
=====================================

Name: sudoku_ram_arbiter

Overview:
- Shares one single-port game-board RAM between two requesters.
- Requester A is the interface controller, with read and write access. Requester B is the game checker, read-only.
- Fixed priority to A, with an anti-starvation limit for B.
- Registers RAM commands, tracks in-flight reads and routes each read result back to its owner with a valid pulse.
- Replaces the dual-port RAM arrangement in the top level, so the board fits a single-port memory.

Parameters:
- ADDR_W, 2, RAM address width (4 board rows).
- DATA_W, 20, RAM word width (4 cells x {protect bit, 4-bit value}).
- READ_LAT, 1, RAM read latency in cycles from registered command to q valid; legal values 1..3.
- STARVE_LIM, 4, consecutive cycles B may be denied before B is forced to win; legal values 1..15.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset, synchronous, active-high.
- a_req  in  1  A request; held until a_ack.
- a_we  in  1  A operation: 1 = write, 0 = read.
- a_addr  in  ADDR_W  A address.
- a_wdata  in  DATA_W  A write data.
- a_ack  out  1  A request accepted this cycle (combinational).
- a_rvalid  out  1  A read data valid (1-cycle pulse).
- a_rdata  out  DATA_W  A read data.
- b_req  in  1  B read request; held until b_ack.
- b_addr  in  ADDR_W  B address.
- b_ack  out  1  B request accepted this cycle (combinational).
- b_rvalid  out  1  B read data valid (1-cycle pulse).
- b_rdata  out  DATA_W  B read data.
- ram_addr  out  ADDR_W  RAM address (registered).
- ram_wdata  out  DATA_W  RAM write data (registered).
- ram_wren  out  1  RAM write enable (registered).
- ram_q  in  DATA_W  RAM read data.

Behaviour:
- Reset (RST=1 at a rising edge) clears:
  - ram_addr=0, ram_wdata=0, ram_wren=0.
  - a_rvalid=0, b_rvalid=0, a_rdata=0, b_rdata=0.
  - Wait counter = 0; in-flight pipeline cleared.
- a_ack and b_ack are forced 0 while RST=1.
- Grant, at most one per cycle, decided combinationally:
  - a_req only -> A.
  - b_req only -> B.
  - Both requesting -> A, unless wait_cnt >= STARVE_LIM, then B.
  - Neither -> no grant.
- wait_cnt (4-bit, saturating at 15):
  - Increments each cycle b_req=1 and b_ack=0.
  - Clears on b_ack, or when b_req=0.
- Requests are not queued. A requester that is not acked keeps req and its operands stable; the arbiter takes no action until ack.
- Command register, at the edge following an ack:
  - ram_addr = granted address.
  - ram_wren = a_we if A was granted, else 0.
  - ram_wdata = a_wdata if A was granted, else held.
- No grant -> ram_wren=0 next cycle; ram_addr and ram_wdata hold.
- Read tracking:
  - A shift register of depth 1+READ_LAT carries {valid, owner} for each granted read.
  - A read acked in cycle N returns its rvalid pulse and rdata in cycle N+1+READ_LAT.
  - rdata is registered from ram_q, sampled READ_LAT cycles after the command was registered.
  - rdata holds its last value when rvalid=0.
- Writes produce no rvalid.
- Back-to-back grants are fully pipelined: one op per cycle, any mix of owners.
- Ordering: ops reach the RAM in grant order. An A read granted after an A write to the same address returns the new data, assuming the RAM is read-after-write coherent across cycles.
- Reset mid-operation: in-flight reads are discarded and no rvalid is produced for them; a pending write not yet registered is dropped.
- a_we is ignored when a_req=0.
- B has no write path; ram_wren is never 1 as a result of a B grant.

Optional Feature:
- Macro ROUND_ROBIN_EN.
- Defined:
  - Conflicts are resolved round-robin. A 1-bit last_winner register (reset to B, so A wins the first conflict) selects the requester not granted last.
  - last_winner updates on every grant.
  - wait_cnt and STARVE_LIM are unused; wait_cnt logic is removed.
- Undefined: priority-with-starvation-limit as described under Behaviour.

Test Plan:
- A read: reset, preload RAM row 2 = 20'hABCDE; a_req=1, a_we=0, a_addr=2 at cycle 0 -> a_ack=1 in cycle 0; ram_addr=2 in cycle 1; a_rvalid=1 and a_rdata=20'hABCDE in cycle 1+READ_LAT (cycle 2); b_rvalid stays 0.
- Write then read: A writes addr 1 = 20'h12345, then A reads addr 1 on the next cycle -> ram_wren=1 for exactly one cycle; read returns 20'h12345.
- Starvation limit: a_req and b_req held high continuously, STARVE_LIM=4 -> grant pattern A,A,A,A,B,A,A,A,A,B...; b_ack every 5th cycle; each b_rvalid carries the correct row.
- B-only reads: b_req high, b_addr=0,1,2,3 on consecutive acks -> 4 b_rvalid pulses on consecutive cycles, in order; ram_wren=0 throughout.
- Reset mid-operation: issue an A read, assert RST the cycle after a_ack -> no a_rvalid ever appears; all outputs at reset values; a_ack=0 while RST=1.
- With ROUND_ROBIN_EN defined, both requesting continuously -> grants alternate A,B,A,B starting with A.

Source files
------------

// File: rtl/sudoku_ram_arbiter_if.sv
// Bus bundle between the two board-RAM requesters, the arbiter and the single-port RAM.
// The arbiter takes the slave modport; the requester/RAM side takes the master modport.
interface sudoku_ram_arbiter_if #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 20
);
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_ack;
    logic              a_rvalid;
    logic [DATA_W-1:0] a_rdata;
    logic              b_req;
    logic [ADDR_W-1:0] b_addr;
    logic              b_ack;
    logic              b_rvalid;
    logic [DATA_W-1:0] b_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_q;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata, b_req, b_addr, ram_q,
        output a_ack, a_rvalid, a_rdata, b_ack, b_rvalid, b_rdata,
        output ram_addr, ram_wdata, ram_wren
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata, b_req, b_addr, ram_q,
        input  a_ack, a_rvalid, a_rdata, b_ack, b_rvalid, b_rdata,
        input  ram_addr, ram_wdata, ram_wren
    );
endinterface

// File: rtl/sudoku_ram_arbiter.sv
// Shares one single-port board RAM between the interface controller (A, r/w) and the checker
// (B, read-only). Define ROUND_ROBIN_EN for round-robin conflicts instead of A-priority + starvation limit.
module sudoku_ram_arbiter #(
    parameter int ADDR_W     = 2,
    parameter int DATA_W     = 20,
    parameter int READ_LAT   = 1,
    parameter int STARVE_LIM = 4
) (
    input logic                 CLK,
    input logic                 RST,
    sudoku_ram_arbiter_if.slave bus
);

    logic grantA;
    logic grantB;
    logic preferB;

`ifdef ROUND_ROBIN_EN
    typedef enum logic {OWN_A = 1'b0, OWN_B = 1'b1} owner_e;
    owner_e lastWinner;

    always_ff @(posedge CLK) begin
        if (RST)         lastWinner <= OWN_B;
        else if (grantA) lastWinner <= OWN_A;
        else if (grantB) lastWinner <= OWN_B;
    end

    assign preferB = (lastWinner == OWN_A);
`else
    localparam logic [3:0] STARVE_LIM_W = 4'(STARVE_LIM);
    logic [3:0] waitCnt;

    always_ff @(posedge CLK) begin
        if (RST || !bus.b_req || grantB) waitCnt <= '0;
        else if (waitCnt != '1)          waitCnt <= waitCnt + 4'd1;
    end

    assign preferB = (waitCnt >= STARVE_LIM_W);
`endif

    always_comb begin
        grantA = 1'b0;
        grantB = 1'b0;
        if (!RST) begin
            if (bus.a_req && bus.b_req) begin
                grantA = !preferB;
                grantB = preferB;
            end else begin
                grantA = bus.a_req;
                grantB = bus.b_req;
            end
        end
    end

    assign bus.a_ack = grantA;
    assign bus.b_ack = grantB;

    always_ff @(posedge CLK) begin
        if (RST) begin
            bus.ram_addr  <= '0;
            bus.ram_wdata <= '0;
            bus.ram_wren  <= 1'b0;
        end else begin
            bus.ram_wren <= grantA & bus.a_we;
            if (grantA) begin
                bus.ram_addr  <= bus.a_addr;
                bus.ram_wdata <= bus.a_wdata;
            end else if (grantB) begin
                bus.ram_addr <= bus.b_addr;
            end
        end
    end

    // Read tracker: bit 0 of each shift vector is the read granted this cycle, the top bit is the
    // read whose RAM data is on ram_q now and gets registered into rdata at this edge.
    logic [READ_LAT-1:0] pipeValid;
    logic [READ_LAT-1:0] pipeOwnerB;
    logic [READ_LAT:0]   validShift;
    logic [READ_LAT:0]   ownerShift;
    logic                retA;
    logic                retB;

    assign validShift = {pipeValid, (grantA & ~bus.a_we) | grantB};
    assign ownerShift = {pipeOwnerB, grantB};
    assign retA = validShift[READ_LAT] & ~ownerShift[READ_LAT];
    assign retB = validShift[READ_LAT] &  ownerShift[READ_LAT];

    always_ff @(posedge CLK) begin
        if (RST) begin
            pipeValid  <= '0;
            pipeOwnerB <= '0;
        end else begin
            pipeValid  <= validShift[READ_LAT-1:0];
            pipeOwnerB <= ownerShift[READ_LAT-1:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            bus.a_rvalid <= 1'b0;
            bus.b_rvalid <= 1'b0;
            bus.a_rdata  <= '0;
            bus.b_rdata  <= '0;
        end else begin
            bus.a_rvalid <= retA;
            bus.b_rvalid <= retB;
            if (retA) bus.a_rdata <= bus.ram_q;
            if (retB) bus.b_rdata <= bus.ram_q;
        end
    end

endmodule

// File: tb/tb_sudoku_ram_arbiter.sv
// Self-checking bench for sudoku_ram_arbiter: vector table, directed corner sequences, and
// randomized traffic against a transaction-level reference model.
module tb_sudoku_ram_arbiter;
    localparam int ADDR_W     = 2;
    localparam int DATA_W     = 20;
    localparam int READ_LAT   = 1;
    localparam int STARVE_LIM = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sudoku_ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sudoku_ram_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .READ_LAT  (READ_LAT),
        .STARVE_LIM(STARVE_LIM)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    // Board RAM: asynchronous read (READ_LAT=1 means ram_q is sampled the cycle the command is out).
    logic [DATA_W-1:0] tbRam [4];
    logic              plEn = 1'b0;
    logic [1:0]        plAddr = '0;
    logic [DATA_W-1:0] plData = '0;
    always @(posedge clk) begin
        if (plEn) tbRam[plAddr] <= plData;
        else if (bus.ram_wren) tbRam[bus.ram_addr] <= bus.ram_wdata;
    end
    assign bus.ram_q = tbRam[bus.ram_addr];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
        bus.b_req = 1'b0; bus.b_addr = '0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic [DATA_W-1:0] rowInit [4];

    task automatic preloadRows();
        for (int r = 0; r < 4; r++) begin
            plEn = 1'b1; plAddr = 2'(r); plData = rowInit[r];
            tick();
        end
        plEn = 1'b0;
    endtask

    function automatic bit expectB(input int c);
`ifdef ROUND_ROBIN_EN
        return (c % 2) == 1;
`else
        return (c % (STARVE_LIM + 1)) == STARVE_LIM;
`endif
    endfunction

    typedef struct {
        logic aReq; logic aWe; logic [1:0] aAddr; logic [19:0] aWdata;
        logic bReq; logic [1:0] bAddr;
        logic expAAck; logic expBAck; logic expWren; logic [1:0] expAddr;
        logic expARv; logic expBRv; logic [19:0] expData;
    } vec_t;
    vec_t vecs [8];

    typedef struct { int due; bit isB; logic [19:0] data; } rd_t;
    rd_t rq [$];

    initial begin
        rowInit[0] = 20'h0A0A0; rowInit[1] = 20'h11111;
        rowInit[2] = 20'hABCDE; rowInit[3] = 20'h33333;
        vecs[0] = '{1'b1, 1'b0, 2'd2, 20'h0,     1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 20'hABCDE};
        vecs[1] = '{1'b0, 1'b0, 2'd0, 20'h0,     1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 20'h11111};
        vecs[2] = '{1'b1, 1'b1, 2'd3, 20'h5A5A5, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 20'h0};
        vecs[3] = '{1'b1, 1'b0, 2'd3, 20'h0,     1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 20'h5A5A5};
        vecs[4] = '{1'b0, 1'b0, 2'd2, 20'h0,     1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 20'h0};
        vecs[5] = '{1'b0, 1'b1, 2'd3, 20'hFFFFF, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 20'hABCDE};
        vecs[6] = '{1'b1, 1'b0, 2'd0, 20'h0,     1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 20'h0A0A0};
        vecs[7] = '{1'b0, 1'b1, 2'd1, 20'h77777, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 20'h0};

        idle();
        rst = 1'b1;
        tick();
        preloadRows();

        // Acks forced low while reset is held, even with both requesting; then reset values.
        bus.a_req = 1'b1; bus.b_req = 1'b1;
        #1;
        chk("rst_a_ack", bus.a_ack, 1'b0);
        chk("rst_b_ack", bus.b_ack, 1'b0);
        doReset();
        chk("rst_ram_addr", bus.ram_addr, 2'd0);
        chk("rst_ram_wdata", bus.ram_wdata, 20'h0);
        chk("rst_ram_wren", bus.ram_wren, 1'b0);
        chk("rst_a_rvalid", bus.a_rvalid, 1'b0);
        chk("rst_b_rvalid", bus.b_rvalid, 1'b0);
        chk("rst_a_rdata", bus.a_rdata, 20'h0);
        chk("rst_b_rdata", bus.b_rdata, 20'h0);

        // Single-transaction vectors, each from a fresh reset.
        for (int i = 0; i < 8; i++) begin
            doReset();
            bus.a_req = vecs[i].aReq; bus.a_we = vecs[i].aWe; bus.a_addr = vecs[i].aAddr;
            bus.a_wdata = vecs[i].aWdata; bus.b_req = vecs[i].bReq; bus.b_addr = vecs[i].bAddr;
            #1;
            chk($sformatf("vec%0d_a_ack", i), bus.a_ack, vecs[i].expAAck);
            chk($sformatf("vec%0d_b_ack", i), bus.b_ack, vecs[i].expBAck);
            tick();
            idle();
            chk($sformatf("vec%0d_wren", i), bus.ram_wren, vecs[i].expWren);
            chk($sformatf("vec%0d_addr", i), bus.ram_addr, vecs[i].expAddr);
            if (vecs[i].expWren) chk($sformatf("vec%0d_wdata", i), bus.ram_wdata, vecs[i].aWdata);
            tick();
            chk($sformatf("vec%0d_a_rvalid", i), bus.a_rvalid, vecs[i].expARv);
            chk($sformatf("vec%0d_b_rvalid", i), bus.b_rvalid, vecs[i].expBRv);
            if (vecs[i].expARv) chk($sformatf("vec%0d_a_rdata", i), bus.a_rdata, vecs[i].expData);
            if (vecs[i].expBRv) chk($sformatf("vec%0d_b_rdata", i), bus.b_rdata, vecs[i].expData);
        end

        // Write then read of the same row on back-to-back cycles.
        doReset();
        bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 2'd1; bus.a_wdata = 20'h12345;
        #1 chk("wr_ack", bus.a_ack, 1'b1);
        tick();
        chk("wr_wren_on", bus.ram_wren, 1'b1);
        chk("wr_wdata", bus.ram_wdata, 20'h12345);
        bus.a_we = 1'b0;
        #1 chk("rd_ack", bus.a_ack, 1'b1);
        tick();
        chk("wr_wren_off", bus.ram_wren, 1'b0);
        idle();
        tick();
        chk("raw_a_rvalid", bus.a_rvalid, 1'b1);
        chk("raw_a_rdata", bus.a_rdata, 20'h12345);
        tick();
        chk("raw_a_rvalid_pulse", bus.a_rvalid, 1'b0);

        // Both requesters held high: starvation limit (or alternation under round-robin).
        preloadRows();
        begin
            bit gotB [16];
            logic [1:0] bA [16];
            doReset();
            bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 2'd0;
            bus.b_req = 1'b1; bus.b_addr = 2'd0;
            for (int c = 0; c < 16; c++) begin
                if (c >= 2) begin
                    chk($sformatf("starve_b_rvalid_c%0d", c), bus.b_rvalid, gotB[c-2]);
                    if (gotB[c-2]) chk($sformatf("starve_b_rdata_c%0d", c), bus.b_rdata, rowInit[bA[c-2]]);
                end
                #1;
                gotB[c] = expectB(c);
                bA[c] = bus.b_addr;
                chk($sformatf("starve_a_ack_c%0d", c), bus.a_ack, !gotB[c]);
                chk($sformatf("starve_b_ack_c%0d", c), bus.b_ack, gotB[c]);
                tick();
                if (gotB[c]) bus.b_addr = bus.b_addr + 2'd1;
            end
        end

        // B-only reads of every row on consecutive cycles.
        doReset();
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("bonly_b_rvalid_c%0d", c), bus.b_rvalid, (c >= 2));
            if (c >= 2) chk($sformatf("bonly_b_rdata_c%0d", c), bus.b_rdata, rowInit[c-2]);
            chk($sformatf("bonly_wren_c%0d", c), bus.ram_wren, 1'b0);
            if (c < 4) begin
                bus.b_req = 1'b1; bus.b_addr = 2'(c);
            end else begin
                idle();
            end
            #1 chk($sformatf("bonly_b_ack_c%0d", c), bus.b_ack, (c < 4));
            tick();
        end

        // Reset the cycle after an A read is acked: its result must never appear.
        doReset();
        bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 2'd2;
        #1 chk("midrst_first_ack", bus.a_ack, 1'b1);
        tick();
        rst = 1'b1;
        #1 chk("midrst_a_ack_in_rst", bus.a_ack, 1'b0);
        tick();
        chk("midrst_ram_addr", bus.ram_addr, 2'd0);
        chk("midrst_wren", bus.ram_wren, 1'b0);
        chk("midrst_a_rdata", bus.a_rdata, 20'h0);
        rst = 1'b0;
        idle();
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("midrst_a_rvalid_%0d", c), bus.a_rvalid, 1'b0);
            tick();
        end

        // Randomized traffic against a transaction-level model.
        begin
            logic [19:0] mMem [4];
            int mWait;
            bit mLastB;
            bit expWren;
            logic [1:0] expAddr;
            logic [19:0] expWdata, expAR, expBR;
            bit aPend, aWe, bPend;
            logic [1:0] aAddr, bAddr;
            logic [19:0] aWdata;
            for (int r = 0; r < 4; r++) begin
                rowInit[r] = 20'($urandom);
                mMem[r] = rowInit[r];
            end
            preloadRows();
            doReset();
            mWait = 0; mLastB = 1'b1; expWren = 1'b0; expAddr = '0; expWdata = '0;
            expAR = '0; expBR = '0; aPend = 1'b0; bPend = 1'b0;
            aWe = 1'b0; aAddr = '0; bAddr = '0; aWdata = '0;
            for (int c = 0; c < 600; c++) begin
                bit eA, eB, gA, gB, bReqNow;
                rd_t e;
                eA = 1'b0; eB = 1'b0;
                if (rq.size() > 0 && rq[0].due == c) begin
                    e = rq.pop_front();
                    if (e.isB) begin eB = 1'b1; expBR = e.data; end
                    else begin eA = 1'b1; expAR = e.data; end
                end
                chk("rnd_a_rvalid", bus.a_rvalid, eA);
                chk("rnd_b_rvalid", bus.b_rvalid, eB);
                chk("rnd_a_rdata", bus.a_rdata, expAR);
                chk("rnd_b_rdata", bus.b_rdata, expBR);
                chk("rnd_wren", bus.ram_wren, expWren);
                chk("rnd_addr", bus.ram_addr, expAddr);
                if (expWren) chk("rnd_wdata", bus.ram_wdata, expWdata);

                if (!aPend && $urandom_range(0, 3) != 0) begin
                    aPend = 1'b1; aWe = 1'($urandom_range(0, 1));
                    aAddr = 2'($urandom_range(0, 3)); aWdata = 20'($urandom);
                end
                if (!bPend && $urandom_range(0, 3) != 0) begin
                    bPend = 1'b1; bAddr = 2'($urandom_range(0, 3));
                end
                bus.a_req = aPend;
                bus.a_we = aPend ? aWe : 1'($urandom_range(0, 1));
                bus.a_addr = aAddr; bus.a_wdata = aWdata;
                bus.b_req = bPend; bus.b_addr = bAddr;
                #1;

                if (aPend && bPend) begin
`ifdef ROUND_ROBIN_EN
                    gB = !mLastB;
`else
                    gB = (mWait >= STARVE_LIM);
`endif
                    gA = !gB;
                end else begin
                    gA = aPend; gB = bPend;
                end
                chk("rnd_a_ack", bus.a_ack, gA);
                chk("rnd_b_ack", bus.b_ack, gB);

                bReqNow = bPend;
                expWren = gA && aWe;
                if (gA) begin
                    expAddr = aAddr; expWdata = aWdata;
                    if (aWe) mMem[aAddr] = aWdata;
                    else rq.push_back('{c + 1 + READ_LAT, 1'b0, mMem[aAddr]});
                    aPend = 1'b0;
                end
                if (gB) begin
                    expAddr = bAddr;
                    rq.push_back('{c + 1 + READ_LAT, 1'b1, mMem[bAddr]});
                    bPend = 1'b0;
                end
                if (gA || gB) mLastB = gB;
                mWait = (bReqNow && !gB) ? ((mWait < 15) ? mWait + 1 : 15) : 0;
                tick();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
